// File: rtl/cpu_trace_monitor_if.sv
// cpu_trace_monitor_if: retire/data-strobe bus from the CPU and the
// trace drain handshake (rd_req in, rd_valid + popped entry out).
interface cpu_trace_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              retire;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] alu_r;
  logic              DM_CS;
  logic              DM_R;
  logic              DM_W;
  logic              rd_req;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_inst;
  logic [DATA_W-1:0] rd_alu;
  logic [2:0]        rd_flags;

  modport master (
    output retire, pc, inst, alu_r,
    output DM_CS, DM_R, DM_W, rd_req,
    input  rd_valid, rd_pc, rd_inst,
    input  rd_alu, rd_flags
  );

  modport slave (
    input  retire, pc, inst, alu_r,
    input  DM_CS, DM_R, DM_W, rd_req,
    output rd_valid, rd_pc, rd_inst,
    output rd_alu, rd_flags
  );
endinterface

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: run monitor for the single-cycle CPU. Captures
// retired instructions into a circular trace, detects pc self-loop
// halt or cycle-budget timeout, flags data-memory strobe misuse and
// lets a host drain the trace oldest-first once stopped.
// Ports: clk_in, reset (sync, active-high), start, bus (slave side of
// cpu_trace_monitor_if), running/done, sticky halted/timeout/overflow/
// proto_err, cycle_cnt (RUN cycles), count (valid trace entries).
module cpu_trace_monitor #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int HALT_CNT   = 4,
  parameter int MAX_CYCLES = 1024,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  cpu_trace_monitor_if.slave bus,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic             overflow,
  output logic             proto_err,
  output logic [31:0]      cycle_cnt,
  output logic [CNT_W-1:0] count
);

  localparam int REP_W = $clog2(HALT_CNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] alu;
    logic [2:0]        flags;
  } entry_t;

  state_t            state;
  entry_t            mem [DEPTH];
  entry_t            wr_entry;
  entry_t            rd_q;
  logic              rd_valid_q;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [REP_W-1:0]  rep;
  logic [REP_W-1:0]  rep_nxt;
  logic [ADDR_W-1:0] prev_pc;
  logic              have_prev;

  logic dm_err;
  logic cap;
  logic full;
  logic same_pc;
  logic hit_halt;
  logic last_cyc;
  logic pop;
  logic restart;

  assign wr_entry = '{
    pc:    bus.pc,
    inst:  bus.inst,
    alu:   bus.alu_r,
    flags: {bus.DM_CS, bus.DM_R, bus.DM_W}
  };

  assign dm_err = bus.retire &
    ((bus.DM_R & bus.DM_W) |
     ((bus.DM_R | bus.DM_W) & ~bus.DM_CS));

  assign cap      = (state == RUN) & bus.retire;
  assign full     = (count == CNT_W'(DEPTH));
  // first retire of a run has no predecessor to compare against
  assign same_pc  = have_prev & (bus.pc == prev_pc);
  assign rep_nxt  = same_pc ? rep + REP_W'(1) : '0;
  assign hit_halt = cap & same_pc &
                    (rep_nxt == REP_W'(HALT_CNT));
  assign last_cyc = (cycle_cnt == 32'(MAX_CYCLES - 1));
  // start outranks a drain request in STOP
  assign restart  = start & (state != RUN);
  assign pop      = (state == STOP) & ~start &
                    bus.rd_req & (count != '0);

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_pc    = rd_q.pc;
  assign bus.rd_inst  = rd_q.inst;
  assign bus.rd_alu   = rd_q.alu;
  assign bus.rd_flags = rd_q.flags;

  // trace storage kept reset-free so it maps onto a plain RAM
  always_ff @(posedge clk_in) begin
    if (!reset && cap) begin
      mem[wptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
      cycle_cnt  <= '0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      rep        <= '0;
      prev_pc    <= '0;
      have_prev  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      rd_valid_q <= pop;
      proto_err  <= (proto_err & ~restart) | dm_err;
      unique case (state)
        IDLE, STOP: begin
          if (restart) begin
            state     <= RUN;
            running   <= 1'b1;
            done      <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            rep       <= '0;
            have_prev <= 1'b0;
          end else if (pop) begin
            rd_q  <= mem[rptr];
            rptr  <= rptr + 1'b1;
            count <= count - 1'b1;
          end
        end
        RUN: begin
          if (last_cyc) begin
            timeout <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
          if (bus.retire) begin
            wptr      <= wptr + 1'b1;
            prev_pc   <= bus.pc;
            have_prev <= 1'b1;
            rep       <= rep_nxt;
            // full buffer: drop the oldest entry
            if (full) begin
              rptr     <= rptr + 1'b1;
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
          if (hit_halt) begin
            halted <= 1'b1;
          end
          if (hit_halt | last_cyc) begin
            state   <= STOP;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed scenarios plus random traffic,
// compared every cycle against a queue-based run model.
module tb_cpu_trace_monitor;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int HC    = 4;
  localparam int MC    = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic          running;
  logic          done;
  logic          halted;
  logic          timeout;
  logic          overflow;
  logic          proto_err;
  logic [31:0]   cycle_cnt;
  logic [CW-1:0] count;

  cpu_trace_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cpu_trace_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
    .HALT_CNT(HC), .MAX_CYCLES(MC)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .start(start),
    .bus(bus.slave),
    .running(running),
    .done(done),
    .halted(halted),
    .timeout(timeout),
    .overflow(overflow),
    .proto_err(proto_err),
    .cycle_cnt(cycle_cnt),
    .count(count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [2:0]  fl;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 run, 2 stop
  ent_t        trq[$];
  logic [31:0] runpcs[$];
  int          m_state = 0;
  int          m_cyc   = 0;
  bit          m_halt, m_tmo, m_ovf, m_perr, m_rdv;
  ent_t        m_rd = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    trq.delete();
    runpcs.delete();
    m_cyc  = 0;
    m_halt = 0;
    m_tmo  = 0;
    m_ovf  = 0;
  endtask

  task automatic model_edge();
    bit err, hlt, tmo;
    int reps;
    err = bus.retire &&
          ((bus.DM_R && bus.DM_W) ||
           ((bus.DM_R || bus.DM_W) && !bus.DM_CS));
    m_rdv = 0;
    if (reset) begin
      m_clear();
      m_state = 0;
      m_perr  = 0;
      m_rd    = '0;
    end else if (m_state == 1) begin
      hlt = 0;
      if (bus.retire) begin
        trq.push_back('{bus.pc, bus.inst, bus.alu_r,
                        {bus.DM_CS, bus.DM_R, bus.DM_W}});
        if (trq.size() > DEPTH) begin
          void'(trq.pop_front());
          m_ovf = 1;
        end
        runpcs.push_back(bus.pc);
        reps = 0;
        for (int i = runpcs.size() - 2;
             i >= 0 && runpcs[i] == bus.pc; i--)
          reps++;
        hlt = (reps >= HC);
      end
      tmo = (m_cyc == MC - 1);
      if (tmo) m_tmo = 1;
      else m_cyc++;
      if (hlt) m_halt = 1;
      if (hlt || tmo) m_state = 2;
      m_perr = m_perr | err;
    end else begin
      if (start) begin
        m_clear();
        m_state = 1;
        m_perr  = 0;
      end else if (m_state == 2 && bus.rd_req &&
                   trq.size() > 0) begin
        m_rdv = 1;
        m_rd  = trq.pop_front();
      end
      m_perr = m_perr | err;
    end
  endtask

  task automatic check_all();
    chk("running", running, 64'(m_state == 1));
    chk("done", done, 64'(m_state == 2));
    chk("flags", {halted, timeout, overflow, proto_err},
        {m_halt, m_tmo, m_ovf, m_perr});
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("count", count, trq.size());
    chk("rd_valid", bus.rd_valid, m_rdv);
    if (m_rdv) begin
      chk("rd_pc", bus.rd_pc, m_rd.pc);
      chk("rd_inst", bus.rd_inst, m_rd.inst);
      chk("rd_alu", bus.rd_alu, m_rd.alu);
      chk("rd_flags", bus.rd_flags, m_rd.fl);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit st, input bit rt,
                       input logic [31:0] p,
                       input logic [2:0] fl,
                       input bit rq);
    start      = st;
    bus.retire = rt;
    bus.pc     = p;
    bus.inst   = $urandom;
    bus.alu_r  = $urandom;
    {bus.DM_CS, bus.DM_R, bus.DM_W} = fl;
    bus.rd_req = rq;
    tick();
  endtask

  function automatic logic [2:0] legal_fl();
    logic [2:0] t [4] = '{3'b000, 3'b100, 3'b110, 3'b101};
    return t[$urandom_range(0, 3)];
  endfunction

  task automatic idle();
    drive(0, 0, 0, 3'b000, 0);
  endtask

  logic [31:0] pl [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
                          32'h10, 32'h10, 32'h10, 32'h10};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    start      = 0;
    bus.retire = 0;
    bus.pc     = 0;
    bus.inst   = 0;
    bus.alu_r  = 0;
    bus.DM_CS  = 0;
    bus.DM_R   = 0;
    bus.DM_W   = 0;
    bus.rd_req = 0;
    reset      = 1;
    repeat (2) tick();
    chk("rst_rd_pc", bus.rd_pc, 0);
    chk("rst_rd_flags", bus.rd_flags, 0);
    reset = 0;
    idle();

    // basic capture and drain
    drive(1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 9; i++)
      drive(0, 1, pl[i], legal_fl(), 0);
    chk("basic_halted", halted, 1);
    chk("basic_count", count, 9);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 3'b000, 1);
      if (i < 9) chk("basic_pc", bus.rd_pc, pl[i]);
      else chk("basic_empty", bus.rd_valid, 0);
    end
    idle();

    // overflow: 24 writes into 16 entries
    drive(1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 20; i++)
      drive(0, 1, 32'(i * 4), legal_fl(), 0);
    for (int i = 0; i < 4; i++)
      drive(0, 1, 32'h4C, legal_fl(), 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);
    drive(0, 0, 0, 3'b000, 1);
    chk("ovf_first_pc", bus.rd_pc, 32'h20);
    for (int i = 0; i < 15; i++)
      drive(0, 0, 0, 3'b000, 1);
    chk("ovf_drained", count, 0);
    idle();

    // timeout with a never-repeating pc
    drive(1, 0, 0, 3'b000, 0);
    for (int k = 0; k < 100 && !done; k++)
      drive(0, 1, 32'h1000 + 32'(k * 4), legal_fl(), 0);
    chk("tmo_done", done, 1);
    chk("tmo_flag", timeout, 1);
    chk("tmo_halted", halted, 0);
    chk("tmo_cycles", cycle_cnt, MC - 1);

    // halt lands on the last budget cycle
    drive(1, 0, 0, 3'b000, 0);
    for (int k = 0; k < MC; k++)
      drive(0, 1, k < MC - 5 ? 32'h2000 + 32'(k * 4)
                             : 32'h3000, legal_fl(), 0);
    chk("both_halted", halted, 1);
    chk("both_timeout", timeout, 1);

    // strobe protocol error
    drive(1, 0, 0, 3'b000, 0);
    drive(0, 1, 32'h100, 3'b001, 0);
    chk("perr_set", proto_err, 1);
    for (int i = 0; i < 5; i++)
      drive(0, 1, 32'h104, legal_fl(), 0);
    chk("perr_stop", done, 1);
    chk("perr_sticky", proto_err, 1);
    drive(0, 0, 0, 3'b000, 1);
    chk("perr_entry", bus.rd_flags, 3'b001);
    idle();

    // reset mid-run
    drive(1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 10; i++)
      drive(0, 1, 32'h500 + 32'(i * 4), legal_fl(), 0);
    reset = 1;
    drive(1, 1, 0, 3'b011, 1);
    chk("rst_running", running, 0);
    chk("rst_count", count, 0);
    reset = 0;
    idle();

    // restart with undrained entries
    drive(1, 0, 0, 3'b000, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 1, 32'h700, legal_fl(), 0);
    drive(0, 0, 0, 3'b000, 1);
    drive(0, 0, 0, 3'b000, 1);
    chk("rs_left", count, 3);
    drive(1, 0, 0, 3'b000, 0);
    chk("rs_count", count, 0);
    chk("rs_run", running, 1);
    chk("rs_halted", halted, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 3) * 4),
            $urandom_range(0, 7) == 0 ? 3'($urandom)
                                      : legal_fl(),
            $urandom_range(0, 1) == 1);
    end
    reset = 0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
